rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (WE/A3/WD3) among N_REQ write-back
//   sources (ALU, LSU, MUL/DIV) using round-robin arbitration with valid/ready handshakes.
//   Issues one registered write per cycle and drops writes to x0.
//   Runs a clear sweep that zeroes x1..x31 after reset or on request.
//   Sits between the execute/memory stages and RF.
// PARAMETERS
//   N_REQ      3   number of write-back requesters (2..8)
//   AW         5   register address width
//   DW         32  register data width
//   INIT_CLEAR 1   1: sweep-clear x1..x31 after reset; 0: start directly in RUN
// PORTS
//   clk        in   1          single clock; all state on rising edge
//   reset      in   1          asynchronous, active-low reset
//   clear_req  in   1          sync pulse: restart clear sweep (ignored while busy)
//   req_valid  in   N_REQ      requester i has a write pending
//   req_addr   in   N_REQ*AW   dest register, requester i at [i*AW +: AW]
//   req_data   in   N_REQ*DW   write data, requester i at [i*DW +: DW]
//   req_ready  out  N_REQ      one-hot grant; beat accepted when valid&ready
//   rf_we      out  1          to RF WE
//   rf_a3      out  AW         to RF A3
//   rf_wd3     out  DW         to RF WD3
//   busy       out  1          1 while in INIT (clear sweep running)
// BEHAVIOUR
//   Reset (reset=0, async): rf_we=0, rf_a3=0, rf_wd3=0, rr_ptr=0, sweep cnt=1.
//     State goes to INIT if INIT_CLEAR=1, else RUN.
//     req_ready=0 while reset is asserted. busy=(state==INIT).
//   States
//     INIT: req_ready=0. Each cycle registers rf_we=1, rf_a3=cnt, rf_wd3=0, then cnt++.
//       Writing cnt==31 -> RUN next cycle, cnt reloads to 1.
//       Result: exactly 31 consecutive writes to x1..x31. x0 is never written.
//     RUN: round-robin grant among asserted req_valid, searching from rr_ptr upward
//       with wrap at N_REQ.
//       - req_ready is combinational: one-hot to the winner, all 0 if no valid.
//       - On grant to i: rr_ptr <= (i+1) mod N_REQ; otherwise rr_ptr is held.
//       - Granted beat is registered: rf_a3/rf_wd3 <= req_addr/req_data[i].
//       - rf_we <= (addr != 0). An x0 write is accepted (ready=1) but rf_we stays 0.
//       - No grant: rf_we <= 0; rf_a3/rf_wd3 hold their last value.
//       - Latency: accept at edge k -> rf_we=1 during cycle k..k+1; RF commits at edge k+1.
//       - Throughput: 1 write per cycle. No buffering and no backpressure from RF.
//       - Requesters must hold valid/addr/data stable until accepted.
//   clear_req in RUN: no grant that cycle (req_ready=0); state -> INIT next edge.
//     A beat registered on the previous edge still commits normally.
//   clear_req in INIT: ignored; sweep continues uninterrupted.
//   Async reset mid-sweep or mid-write: any in-flight output beat is discarded
//     (rf_we forced 0 immediately). Sweep restarts from x1 if INIT_CLEAR=1.
//   Unused upper N_REQ bits of rr_ptr cannot occur. Pointer width = clog2(N_REQ).
// TESTING
//   1 Reset release, INIT_CLEAR=1 -> busy=1 for 31 cycles, rf_we=1 with rf_a3=1..31
//     and rf_wd3=0 in order, then busy=0. req_ready=0 throughout.
//   2 All 3 valid continuously (addr 5/6/7, data A/B/C), rr_ptr=0 -> grants 0,1,2,0,...
//     rf_a3 = 5,6,7,5 one cycle after each accept.
//   3 Only req1 valid, addr=0, data=FFFF_FFFF -> req_ready[1]=1 for one cycle,
//     rf_we stays 0, rr_ptr -> 2.
//   4 req0 valid while clear_req=1 in RUN -> req_ready=0 that cycle, sweep runs,
//     req0 is then granted first after busy falls.
//   5 reset=0 mid-sweep at cnt=12, held 2 cycles -> rf_we=0 at once, then sweep
//     restarts at x1 after release.
//   6 req2 granted, then req0 and req2 valid on the same cycle -> req0 granted
//     (pointer wrapped to 0).

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin over N_REQ write-back sources, plus x1..x31 clear sweep.
// Latency: a beat accepted at edge k drives rf_we/rf_a3/rf_wd3 during cycle k..k+1 (one registered stage).
// Backpressure: req_ready is a combinational one-hot grant, 0 during sweep, clear_req or reset; RF never stalls.
module rf_wb_arbiter #(
  parameter int N_REQ      = 3,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rf_we,
  output logic [AW-1:0]       rf_a3,
  output logic [DW-1:0]       rf_wd3,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Highest register index; for AW=5 this is x31.
  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_a3_q, rf_a3_d;
  logic [DW-1:0]   rf_wd3_q, rf_wd3_d;
  logic [N_REQ-1:0] grant_oh;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;

  // Round-robin search: first asserted valid starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    int          idx;
    logic [PW-1:0] idx_w;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = PW'(idx);
      if (!grant_vld && req_valid[idx_w]) begin
        grant_vld = 1'b1;
        grant_idx = idx_w;
      end
    end
  end

  assign grant_addr = req_addr[grant_idx*AW +: AW];
  assign grant_data = req_data[grant_idx*DW +: DW];

  // Next-state, grant and registered-write computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    grant_oh = '0;
    case (state_q)
      ST_INIT: begin
        // clear_req is deliberately ignored here; the sweep always completes.
        rf_we_d  = 1'b1;
        rf_a3_d  = cnt_q;
        rf_wd3_d = '0;
        if (cnt_q == LAST_REG) begin
          cnt_d   = AW'(1);
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        if (clear_req) begin
          // No grant this cycle; any beat registered last edge still commits.
          state_d = ST_INIT;
        end else if (grant_vld) begin
          grant_oh[grant_idx] = 1'b1;
          rr_ptr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
          rf_a3_d  = grant_addr;
          rf_wd3_d = grant_data;
          // x0 beats are consumed but never reach the register file.
          rf_we_d  = (grant_addr != '0);
        end
      end
    endcase
  end

  // State and output registers; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_STATE;
      cnt_q    <= AW'(1);
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
    end
  end

  assign req_ready = reset ? grant_oh : '0;
  assign rf_we     = rf_we_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd3    = rf_wd3_q;
  assign busy      = (state_q == ST_INIT);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios then randomized traffic.
// Expected RF writes are queued by a reference model; a negedge monitor pops and compares.
// Grants and busy are checked every cycle against the model.
module tb_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_a3;
  logic [DW-1:0]   rf_wd3;
  logic            busy;

  rf_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .INIT_CLEAR(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;

  // Reference model state
  int          sweep_left = 0;
  int          model_ptr  = 0;
  logic [N-1:0] last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every committed RF write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {27'd0, rf_a3, rf_wd3}, 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(rf_a3), 64'(e.a));
        chk("wr_data", 64'(rf_wd3), 64'(e.d));
      end
    end
  end

  // One clock cycle: check the DUT against the model with current inputs, then advance.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [AW-1:0] a;
    exp_rdy = '0;
    #1;
    if (sweep_left > 0) begin
      chk("busy_init", 64'(busy), 64'd1);
      exp_q.push_back('{a: AW'(32 - sweep_left), d: '0});
      sweep_left--;
    end else begin
      chk("busy_run", 64'(busy), 64'd0);
      if (clear_req) begin
        sweep_left = 31;
      end else begin
        // Winner = first valid requester met walking forward from the pointer.
        for (int k = 0; k < N; k++) begin
          int i;
          i = (model_ptr + k) % N;
          if (exp_rdy == '0 && req_valid[i]) begin
            exp_rdy[i] = 1'b1;
            model_ptr  = (i + 1) % N;
            a = req_addr[i*AW +: AW];
            if (a != 0) exp_q.push_back('{a: a, d: req_data[i*DW +: DW]});
          end
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    last_acc = exp_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    repeat (hold) @(posedge clk);
    #1;
    chk("rst_a3", 64'(rf_a3), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    reset      = 1'b1;
    sweep_left = 31;
    model_ptr  = 0;
  endtask

  initial begin
    reset = 1'b0; clear_req = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we0", 64'(rf_we), 64'd0);
    chk("rst_a30", 64'(rf_a3), 64'd0);
    chk("rst_wd30", 64'(rf_wd3), 64'd0);
    chk("rst_rdy0", 64'(req_ready), 64'd0);
    reset = 1'b1; sweep_left = 31; model_ptr = 0;

    // Reset sweep with all requesters already waiting, then 0,1,2,0,1,2 rotation.
    set_req(0, 1'b1, 5'd5, 32'h0000_000A);
    set_req(1, 1'b1, 5'd6, 32'h0000_000B);
    set_req(2, 1'b1, 5'd7, 32'h0000_000C);
    repeat (31) step();
    repeat (6) step();
    req_valid = '0;
    step();

    // Only req1 with x0: accepted, no write; pointer now 2.
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    req_valid = '0;
    step();
    set_req(0, 1'b1, 5'd3, 32'h1111_1111);
    set_req(1, 1'b1, 5'd4, 32'h2222_2222);
    set_req(2, 1'b1, 5'd8, 32'h3333_3333);
    step();
    req_valid = '0;
    step();

    // req2 granted, then req0 and req2 together: pointer wrapped, req0 wins.
    set_req(2, 1'b1, 5'd9, 32'h4444_4444);
    step();
    set_req(0, 1'b1, 5'd10, 32'h5555_5555);
    step();
    step();
    req_valid = '0;
    step();

    // clear_req with req0 waiting: no grant, full sweep, then req0 first.
    set_req(0, 1'b1, 5'd11, 32'h0000_1234);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (31) step();
    step();
    req_valid = '0;
    step();

    // Reset in the middle of a sweep; in-flight x12 write discarded, sweep restarts.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (12) step();
    req_valid = 3'b111;
    do_reset(2);
    req_valid = '0;
    repeat (33) step();

    // Randomized traffic; requesters hold their beat until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, 1'b1,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)),
                  $urandom);
        end
      end
      clear_req = ($urandom_range(0, 59) == 0);
      step();
      clear_req = 1'b0;
      req_valid = req_valid & ~last_acc;
    end

    req_valid = '0;
    while (sweep_left > 0) step();
    repeat (3) step();
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
